// File: rtl/pcie_tlp_pkg.sv
// Shared PCIe TLP fmt/type constants, completion status codes and
// TX engine state encodings used by the transaction-layer engines.
package pcie_tlp_pkg;

    localparam logic [6:0] MEM_RD = 7'b0000000;
    localparam logic [6:0] MEM_WR = 7'b1000000;
    localparam logic [6:0] CPLD   = 7'b1001010;

    localparam logic [2:0] CPL_SC  = 3'b000;
    localparam logic [2:0] CPL_UR  = 3'b001;
    localparam logic [2:0] CPL_CRS = 3'b010;
    localparam logic [2:0] CPL_CA  = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CPL_B0,
        ST_CPL_B1,
        ST_MRD_B0,
        ST_MRD_B1
    } tx_state_t;

    typedef enum logic {
        SEL_CPLD,
        SEL_MRD
    } tlp_sel_t;

endpackage

// File: rtl/tlp_hdr_fmt.sv
// Combinational builder of the two 64-bit beats of a CplD or 3DW MRd TLP,
// plus the byte enables of the second beat.
module tlp_hdr_fmt
    import pcie_tlp_pkg::*;
(
    input  tlp_sel_t    i_sel,
    input  logic [15:0] i_cpl_id,
    input  logic [2:0]  i_tc,
    input  logic        i_td,
    input  logic        i_ep,
    input  logic [1:0]  i_attr,
    input  logic [15:0] i_rid,
    input  logic [7:0]  i_req_tag,
    input  logic [6:0]  i_lo_addr,
    input  logic [31:0] i_data,
    input  logic [31:0] i_rd_addr,
    input  logic [9:0]  i_rd_len,
    input  logic [7:0]  i_rd_tag,
    output logic [63:0] o_beat0,
    output logic [63:0] o_beat1,
    output logic [7:0]  o_keep1
);

    logic [3:0] w_last_be;

    assign w_last_be = (i_rd_len == 10'd1) ? 4'h0 : 4'hF;

    always_comb begin
        o_beat0 = '0;
        o_beat1 = '0;
        o_keep1 = 8'hFF;
        if (i_sel == SEL_CPLD) begin
            o_beat0 = {i_cpl_id, CPL_SC, 1'b0, 12'd4,
                       1'b0, CPLD, 1'b0, i_tc, 4'b0,
                       i_td, i_ep, i_attr, 2'b0, 10'd1};
            o_beat1 = {i_data, i_rid, i_req_tag, 1'b0, i_lo_addr};
        end else begin
            o_beat0 = {i_cpl_id, i_rd_tag, w_last_be, 4'hF,
                       1'b0, MEM_RD, 14'b0, i_rd_len};
            o_beat1 = {32'b0, i_rd_addr[31:2], 2'b00};
            o_keep1 = 8'h0F;
        end
    end

endmodule

// File: rtl/cpld_tx_engine.sv
// PCIe TX engine: 1DW CplD completions and 3DW MRd DMA reads onto the
// core AXI-S TX port, completions taking priority.
module cpld_tx_engine
    import pcie_tlp_pkg::*;
#(
    parameter int C_DATA_WIDTH = 64,
    parameter int TAG_BITS     = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    output logic [C_DATA_WIDTH-1:0]   s_axis_tx_tdata,
    output logic [C_DATA_WIDTH/8-1:0] s_axis_tx_tkeep,
    output logic                      s_axis_tx_tlast,
    output logic                      s_axis_tx_tvalid,
    input  logic                      s_axis_tx_tready,
    input  logic [15:0]               cfg_completer_id_i,
    input  logic                      req_compl_wd_i,
    output logic                      compl_done_o,
    input  logic [31:0]               tx_reg_data_i,
    input  logic [2:0]                req_tc_i,
    input  logic                      req_td_i,
    input  logic                      req_ep_i,
    input  logic [1:0]                req_attr_i,
    input  logic [9:0]                req_len_i,
    input  logic [15:0]               req_rid_i,
    input  logic [7:0]                req_tag_i,
    input  logic [6:0]                req_addr_i,
    input  logic                      rd_req_i,
    input  logic [31:0]               rd_addr_i,
    input  logic [9:0]                rd_len_i,
    output logic                      rd_ack_o,
    output logic [7:0]                rd_tag_o
);

    tx_state_t         r_state, w_state_nxt;
    logic              r_tvalid, w_tvalid_nxt;
    logic              r_tlast, w_tlast_nxt;
    logic [63:0]       r_tdata, w_tdata_nxt;
    logic [7:0]        r_tkeep, w_tkeep_nxt;
    logic [63:0]       r_beat1, w_beat1_nxt;
    logic [7:0]        r_keep1, w_keep1_nxt;
    logic              r_done, w_done_nxt;
    logic              r_ack, w_ack_nxt;
    logic [TAG_BITS-1:0] r_tag, w_tag_nxt;
    logic [7:0]        r_rd_tag, w_rd_tag_nxt;

    logic              w_go_cpl;
    logic              w_go_mrd;
    tlp_sel_t          w_sel;
    logic [63:0]       w_beat0;
    logic [63:0]       w_beat1;
    logic [7:0]        w_keep1;
    logic              w_unused;

    // CplD length is always 1DW; address bits [1:0] are DW-aligned.
    assign w_unused = ^{req_len_i, rd_addr_i[1:0]};

    // The done/ack term blocks a still-held request in its pulse cycle.
    assign w_go_cpl = req_compl_wd_i && !r_done;
    assign w_go_mrd = rd_req_i && !r_ack && !w_go_cpl;
    assign w_sel    = w_go_cpl ? SEL_CPLD : SEL_MRD;

    tlp_hdr_fmt u_fmt (
        .i_sel     (w_sel),
        .i_cpl_id  (cfg_completer_id_i),
        .i_tc      (req_tc_i),
        .i_td      (req_td_i),
        .i_ep      (req_ep_i),
        .i_attr    (req_attr_i),
        .i_rid     (req_rid_i),
        .i_req_tag (req_tag_i),
        .i_lo_addr (req_addr_i),
        .i_data    (tx_reg_data_i),
        .i_rd_addr (rd_addr_i),
        .i_rd_len  (rd_len_i),
        .i_rd_tag  (8'(r_tag)),
        .o_beat0   (w_beat0),
        .o_beat1   (w_beat1),
        .o_keep1   (w_keep1)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_tvalid_nxt = r_tvalid;
        w_tlast_nxt  = r_tlast;
        w_tdata_nxt  = r_tdata;
        w_tkeep_nxt  = r_tkeep;
        w_beat1_nxt  = r_beat1;
        w_keep1_nxt  = r_keep1;
        w_done_nxt   = 1'b0;
        w_ack_nxt    = 1'b0;
        w_tag_nxt    = r_tag;
        w_rd_tag_nxt = r_rd_tag;
        unique case (r_state)
            ST_IDLE: begin
                if (w_go_cpl || w_go_mrd) begin
                    w_state_nxt  = w_go_cpl ? ST_CPL_B0 : ST_MRD_B0;
                    w_tvalid_nxt = 1'b1;
                    w_tlast_nxt  = 1'b0;
                    w_tdata_nxt  = w_beat0;
                    w_tkeep_nxt  = 8'hFF;
                    w_beat1_nxt  = w_beat1;
                    w_keep1_nxt  = w_keep1;
                end
            end
            ST_CPL_B0, ST_MRD_B0: begin
                if (s_axis_tx_tready) begin
                    w_state_nxt = (r_state == ST_CPL_B0) ? ST_CPL_B1
                                                         : ST_MRD_B1;
                    w_tdata_nxt = r_beat1;
                    w_tkeep_nxt = r_keep1;
                    w_tlast_nxt = 1'b1;
                end
            end
            ST_CPL_B1: begin
                if (s_axis_tx_tready) begin
                    w_state_nxt  = ST_IDLE;
                    w_tvalid_nxt = 1'b0;
                    w_tlast_nxt  = 1'b0;
                    w_done_nxt   = 1'b1;
                end
            end
            ST_MRD_B1: begin
                if (s_axis_tx_tready) begin
                    w_state_nxt  = ST_IDLE;
                    w_tvalid_nxt = 1'b0;
                    w_tlast_nxt  = 1'b0;
                    w_ack_nxt    = 1'b1;
                    w_rd_tag_nxt = 8'(r_tag);
                    w_tag_nxt    = r_tag + TAG_BITS'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tdata  <= '0;
            r_tkeep  <= '0;
            r_beat1  <= '0;
            r_keep1  <= '0;
            r_done   <= 1'b0;
            r_ack    <= 1'b0;
            r_tag    <= '0;
            r_rd_tag <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_tvalid <= w_tvalid_nxt;
            r_tlast  <= w_tlast_nxt;
            r_tdata  <= w_tdata_nxt;
            r_tkeep  <= w_tkeep_nxt;
            r_beat1  <= w_beat1_nxt;
            r_keep1  <= w_keep1_nxt;
            r_done   <= w_done_nxt;
            r_ack    <= w_ack_nxt;
            r_tag    <= w_tag_nxt;
            r_rd_tag <= w_rd_tag_nxt;
        end
    end

    assign s_axis_tx_tdata  = r_tdata;
    assign s_axis_tx_tkeep  = r_tkeep;
    assign s_axis_tx_tlast  = r_tlast;
    assign s_axis_tx_tvalid = r_tvalid;
    assign compl_done_o     = r_done;
    assign rd_ack_o         = r_ack;
    assign rd_tag_o         = r_rd_tag;

endmodule
